// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared state encoding, opcode constants and iteration count for the mul/div unit
package multdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [4:0] OPC_ALU = 5'b00000;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    localparam int ITER_COUNT = 32;

endpackage

// File: rtl/multdiv_iter.sv
// rtl/multdiv_iter.sv - accumulator/remainder registers with one add-shift or restoring-divide step per cycle
// Divide step is built only when MULTDIV_DIV_EN is defined.
module multdiv_iter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         step,
    input  logic         is_div,
    input  logic [W-1:0] a_mag,
    input  logic [W-1:0] b_mag,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    // opnd holds the multiplicand for mul and the divisor for div
    logic [W-1:0] opnd;
    logic [W:0]   mul_sum;
    logic [W-1:0] mul_hi_n;
    logic [W-1:0] mul_lo_n;

    assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    assign mul_hi_n = mul_sum[W:1];
    assign mul_lo_n = {mul_sum[0], lo[W-1:1]};

`ifdef MULTDIV_DIV_EN
    logic         div_mode;
    logic [W:0]   shifted;
    logic [W:0]   trial;
    logic         fits;
    logic [W-1:0] div_hi_n;
    logic [W-1:0] div_lo_n;

    // lo shifts dividend bits out of its top while quotient bits enter at the bottom
    assign shifted  = {hi, lo[W-1]};
    assign trial    = shifted - {1'b0, opnd};
    assign fits     = ~trial[W];
    assign div_hi_n = fits ? trial[W-1:0] : shifted[W-1:0];
    assign div_lo_n = {lo[W-2:0], fits};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hi       <= '0;
            lo       <= '0;
            opnd     <= '0;
            div_mode <= 1'b0;
        end else if (load) begin
            hi       <= '0;
            lo       <= is_div ? a_mag : b_mag;
            opnd     <= is_div ? b_mag : a_mag;
            div_mode <= is_div;
        end else if (step) begin
            hi <= div_mode ? div_hi_n : mul_hi_n;
            lo <= div_mode ? div_lo_n : mul_lo_n;
        end
    end
`else
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hi   <= '0;
            lo   <= '0;
            opnd <= '0;
        end else if (load) begin
            hi   <= '0;
            lo   <= is_div ? a_mag : b_mag;
            opnd <= is_div ? b_mag : a_mag;
        end else if (step) begin
            hi <= mul_hi_n;
            lo <= mul_lo_n;
        end
    end
`endif

endmodule

// File: rtl/x_multdiv_unit.sv
// rtl/x_multdiv_unit.sv - iterative signed multiply/divide for the execute stage
// Divider built only when MULTDIV_DIV_EN is defined; otherwise div reports an exception.
module x_multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int DATA_WIDTH = ITER_COUNT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           insn_in,
    input  logic [DATA_WIDTH-1:0] data_A_in,
    input  logic [DATA_WIDTH-1:0] data_B_in,
    input  logic                  kill,
    output logic                  stall,
    output logic                  busy,
    output logic                  result_valid,
    output logic [DATA_WIDTH-1:0] result_out,
    output logic                  exception
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0]  LAST_ITER = CW'(W - 1);
    localparam logic [2*W-1:0] MAG_LIM   = {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};

    state_t        state, state_n;
    logic [CW-1:0] count;
    logic          iter_load, iter_step;
    logic          neg_q, is_div_q, div_bad_q, div_ovf_q;
    logic [W-1:0]  res_hold;
    logic          exc_hold;

    logic          dec_alu, dec_mul, dec_div, decoded;
    logic          a_neg, b_neg;
    logic [W-1:0]  a_mag, b_mag;
    logic          div_bad_d, div_ovf_d;
    logic [W-1:0]  acc_hi, acc_lo;
    logic          unused_insn_bits;

    assign dec_alu = (insn_in[31:27] == OPC_ALU);
    assign dec_mul = dec_alu && (insn_in[6:2] == ALU_MUL);
    assign dec_div = dec_alu && (insn_in[6:2] == ALU_DIV);
    assign decoded = dec_mul | dec_div;
    assign unused_insn_bits = ^{insn_in[26:7], insn_in[1:0]};

    assign a_neg = data_A_in[W-1];
    assign b_neg = data_B_in[W-1];
    assign a_mag = a_neg ? -data_A_in : data_A_in;
    assign b_mag = b_neg ? -data_B_in : data_B_in;

`ifdef MULTDIV_DIV_EN
    logic b_zero;
    assign b_zero    = (data_B_in == '0);
    assign div_bad_d = b_zero;
    assign div_ovf_d = (data_A_in == {1'b1, {(W-1){1'b0}}}) && (&data_B_in);
`else
    assign div_bad_d = 1'b1;
    assign div_ovf_d = 1'b0;
`endif

    multdiv_iter #(.W(W)) u_iter (
        .clock  (clock),
        .reset  (reset),
        .load   (iter_load),
        .step   (iter_step),
        .is_div (dec_div),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .hi     (acc_hi),
        .lo     (acc_lo)
    );

    always_comb begin
        state_n   = state;
        iter_load = 1'b0;
        iter_step = 1'b0;
        case (state)
            ST_IDLE: begin
                if (decoded && !kill) begin
                    iter_load = 1'b1;
                    if (dec_mul)        state_n = ST_MUL;
                    else if (div_bad_d) state_n = ST_DONE;
                    else                state_n = ST_DIV;
                end
            end
            ST_MUL, ST_DIV: begin
                if (kill) begin
                    state_n = ST_IDLE;
                end else begin
                    iter_step = 1'b1;
                    if (count == LAST_ITER) state_n = ST_DONE;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Magnitudes are unsigned; sign and overflow are recovered from neg_q at DONE
    logic [2*W-1:0] prod_mag;
    logic [W-1:0]   prod_low, quot, done_res;
    logic           mul_ovf, done_exc;

    assign prod_mag = {acc_hi, acc_lo};
    assign prod_low = neg_q ? -acc_lo : acc_lo;
    assign quot     = neg_q ? -acc_lo : acc_lo;
    assign mul_ovf  = neg_q ? (prod_mag > MAG_LIM) : (prod_mag >= MAG_LIM);
    assign done_res = !is_div_q ? prod_low : (div_bad_q ? '0 : quot);
    assign done_exc = is_div_q ? (div_bad_q | div_ovf_q) : mul_ovf;

    assign busy         = (state == ST_MUL) || (state == ST_DIV);
    assign stall        = reset && !kill && (((state == ST_IDLE) && decoded) || busy);
    assign result_valid = (state == ST_DONE) && !kill;
    assign result_out   = result_valid ? done_res : res_hold;
    assign exception    = result_valid ? done_exc : exc_hold;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            count     <= '0;
            neg_q     <= 1'b0;
            is_div_q  <= 1'b0;
            div_bad_q <= 1'b0;
            div_ovf_q <= 1'b0;
            res_hold  <= '0;
            exc_hold  <= 1'b0;
        end else begin
            state <= state_n;
            if (iter_load) begin
                count     <= '0;
                neg_q     <= a_neg ^ b_neg;
                is_div_q  <= dec_div;
                div_bad_q <= div_bad_d;
                div_ovf_q <= div_ovf_d;
            end else if (iter_step) begin
                count <= count + 1'b1;
            end
            if (result_valid) begin
                res_hold <= done_res;
                exc_hold <= done_exc;
            end
        end
    end

endmodule

// File: tb/tb_x_multdiv_unit.sv
// tb/tb_x_multdiv_unit.sv - randomized self-checking bench for x_multdiv_unit against an arithmetic model
module tb_x_multdiv_unit;

    localparam logic [31:0] INSN_MUL   = 32'h0000_0018;
    localparam logic [31:0] INSN_DIV   = 32'h0000_001C;
    localparam logic [31:0] INSN_NOP   = 32'h0000_0000;
    localparam logic [31:0] INSN_BADOP = 32'h0800_0018;
`ifdef MULTDIV_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] insn_in = INSN_NOP;
    logic [31:0] data_A_in = '0;
    logic [31:0] data_B_in = '0;
    logic        kill = 1'b0;
    logic        stall, busy, result_valid, exception;
    logic [31:0] result_out;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] last_res = '0;
    logic        last_exc = 1'b0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    x_multdiv_unit dut (
        .clock        (clock),
        .reset        (reset),
        .insn_in      (insn_in),
        .data_A_in    (data_A_in),
        .data_B_in    (data_B_in),
        .kill         (kill),
        .stall        (stall),
        .busy         (busy),
        .result_valid (result_valid),
        .result_out   (result_out),
        .exception    (exception)
    );

    task automatic model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic e, output int lat);
        int     sa, sb;
        longint p;
        sa = a;
        sb = b;
        if (!is_div) begin
            p   = longint'(sa) * longint'(sb);
            r   = p[31:0];
            e   = (p > 64'sd2147483647) || (p < -64'sd2147483648);
            lat = 33;
        end else if (!DIV_ON || b == 32'd0) begin
            r   = '0;
            e   = 1'b1;
            lat = 1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r   = 32'h8000_0000;
            e   = 1'b1;
            lat = 33;
        end else begin
            r   = sa / sb;
            e   = 1'b0;
            lat = 33;
        end
    endtask

    task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b, input string name);
        logic [31:0] er;
        logic        ee;
        int          lat, c, st;
        bit          got;
        model(is_div, a, b, er, ee, lat);
        @(negedge clock);
        insn_in   = is_div ? INSN_DIV : INSN_MUL;
        data_A_in = a;
        data_B_in = b;
        #1;
        c = 0; st = 0; got = 0;
        while (!got && c < 80) begin
            if (result_valid) got = 1;
            else begin
                if (stall) st++;
                @(negedge clock);
                data_A_in = $urandom;
                data_B_in = $urandom;
                #1;
                c++;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: no result_valid after %0d cycles", name, c);
        end else begin
            checks++;
            if (c !== lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, c, lat); end
            checks++;
            if (st !== lat) begin errors++; $display("FAIL %s stall_cycles: got %0d want %0d", name, st, lat); end
            checks++;
            if (stall !== 1'b0) begin errors++; $display("FAIL %s done_stall: got %b want 0", name, stall); end
            checks++;
            if (result_out !== er) begin errors++; $display("FAIL %s result: got %h want %h", name, result_out, er); end
            checks++;
            if (exception !== ee) begin errors++; $display("FAIL %s exception: got %b want %b", name, exception, ee); end
        end
        insn_in  = INSN_NOP;
        last_res = er;
        last_exc = ee;
        @(negedge clock);
        #1;
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || result_out !== er || exception !== ee) begin
            errors++;
            $display("FAIL %s hold: valid=%b busy=%b res=%h exc=%b want 0 0 %h %b",
                     name, result_valid, busy, result_out, exception, er, ee);
        end
    endtask

    task automatic test_reset();
        insn_in   = INSN_MUL;
        data_A_in = 32'd3;
        data_B_in = 32'd4;
        repeat (2) @(negedge clock);
        #1;
        checks++;
        if (stall !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0 || result_out !== 32'd0 || exception !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: stall=%b busy=%b valid=%b res=%h exc=%b want all 0",
                     stall, busy, result_valid, result_out, exception);
        end
        insn_in = INSN_NOP;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_decode();
        insn_in = INSN_BADOP;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            checks++;
            if (stall !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL decode_badop: stall=%b busy=%b want 0 0", stall, busy);
            end
        end
        insn_in = INSN_NOP;
    endtask

    task automatic test_directed();
        run_op(0, 32'd7, -32'sd6, "mul_7_x_m6");
        run_op(0, 32'h0001_0000, 32'h0001_0000, "mul_ovf");
        run_op(0, 32'h8000_0000, 32'd1, "mul_intmin_x_1");
        run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, "mul_intmin_x_m1");
        run_op(0, 32'd0, -32'sd5, "mul_zero_neg");
        run_op(1, -32'sd7, 32'd2, "div_m7_by_2");
        run_op(1, 32'd5, 32'd0, "div_by_zero");
        run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, "div_intmin_by_m1");
        run_op(1, 32'd8, 32'd2, "div_8_by_2");
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = $urandom_range(0, 200) - 100; b = $urandom_range(0, 200) - 100; end
                2: begin a = $urandom; b = 32'd0; end
                default: begin a = $urandom & 32'h0000_FFFF; b = 32'hFFFF_0000 | $urandom; end
            endcase
            run_op(i[0], a, b, i[0] ? "rand_div" : "rand_mul");
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, r1, r2;
        logic        e1, e2;
        int          lat, t1, t2, c;
        a1 = $urandom; b1 = $urandom_range(0, 5000);
        a2 = $urandom_range(0, 5000) - 2500; b2 = $urandom;
        model(0, a1, b1, r1, e1, lat);
        model(0, a2, b2, r2, e2, lat);
        @(negedge clock);
        insn_in = INSN_MUL; data_A_in = a1; data_B_in = b1;
        #1;
        c = 0;
        while (!result_valid && c < 80) begin @(negedge clock); #1; c++; end
        t1 = cyc;
        checks++;
        if (!result_valid || result_out !== r1 || exception !== e1) begin
            errors++;
            $display("FAIL b2b_first: valid=%b res=%h exc=%b want 1 %h %b", result_valid, result_out, exception, r1, e1);
        end
        data_A_in = a2; data_B_in = b2;
        @(negedge clock);
        #1;
        checks++;
        if (stall !== 1'b1 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_fresh_detect: stall=%b valid=%b want 1 0", stall, result_valid);
        end
        c = 0;
        while (!result_valid && c < 80) begin @(negedge clock); #1; c++; end
        t2 = cyc;
        checks++;
        if (!result_valid || t2 - t1 !== 34) begin
            errors++;
            $display("FAIL b2b_spacing: valid=%b gap=%0d want 1 34", result_valid, t2 - t1);
        end
        checks++;
        if (result_out !== r2 || exception !== e2) begin
            errors++;
            $display("FAIL b2b_second: res=%h exc=%b want %h %b", result_out, exception, r2, e2);
        end
        insn_in  = INSN_NOP;
        last_res = r2;
        last_exc = e2;
        @(negedge clock);
    endtask

    task automatic test_kill(input int at, input string name);
        int pulses;
        @(negedge clock);
        insn_in = INSN_MUL; data_A_in = $urandom; data_B_in = $urandom;
        #1;
        for (int i = 0; i < at; i++) begin @(negedge clock); #1; end
        kill = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s kill_cycle: stall=%b valid=%b want 0 0", name, stall, result_valid);
        end
        @(negedge clock);
        kill = 1'b0; insn_in = INSN_NOP;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_after_kill: got %b want 0", name, busy); end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (result_valid) pulses++;
            @(negedge clock); #1;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL %s pulses: got %0d want 0", name, pulses); end
        checks++;
        if (result_out !== last_res || exception !== last_exc) begin
            errors++;
            $display("FAIL %s held_result: res=%h exc=%b want %h %b", name, result_out, exception, last_res, last_exc);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        insn_in   = DIV_ON ? INSN_DIV : INSN_MUL;
        data_A_in = $urandom | 32'h1;
        data_B_in = $urandom_range(1, 1000);
        repeat (15) @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (result_out !== 32'd0 || result_valid !== 1'b0 || exception !== 1'b0 || busy !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: res=%h valid=%b exc=%b busy=%b stall=%b want all 0",
                     result_out, result_valid, exception, busy, stall);
        end
        @(negedge clock);
        insn_in = INSN_NOP;
        @(negedge clock);
        reset    = 1'b1;
        last_res = '0;
        last_exc = 1'b0;
        run_op(0, $urandom, $urandom_range(0, 70000), "mul_after_reset");
    endtask

    initial begin
        test_reset();
        test_decode();
        test_directed();
        test_random();
        test_back_to_back();
        test_kill(10, "kill_c10");
        test_kill(32, "kill_last_iter");
        test_kill(0, "kill_in_idle");
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
